// File: rtl/lvt_read_select_if.sv
// rtl/lvt_read_select_if.sv - write/read/bank-data bundle for the LVT read selector.
// Master drives writes, reads and bank RAM outputs; slave returns selected words.
interface lvt_read_select_if #(
   parameter int NUM_BANKS = 4,
   parameter int NUM_READ  = 4,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 9,
   parameter int SEL_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) ();
   logic [NUM_BANKS-1:0]                 wr_en;
   logic [NUM_BANKS*ADDR_W-1:0]          wr_addr;
   logic [NUM_BANKS*DATA_W-1:0]          wr_data;
   logic [NUM_READ-1:0]                  rd_en;
   logic [NUM_READ*ADDR_W-1:0]           rd_addr;
   logic [NUM_READ*NUM_BANKS*DATA_W-1:0] bank_rd_data;
   logic [NUM_READ*DATA_W-1:0]           rd_data;
   logic [NUM_READ-1:0]                  rd_valid;
   logic [NUM_READ*SEL_W-1:0]            rd_bank;

   modport master (
      output wr_en, wr_addr, wr_data, rd_en, rd_addr, bank_rd_data,
      input  rd_data, rd_valid, rd_bank
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr, bank_rd_data,
      output rd_data, rd_valid, rd_bank
   );
endinterface

// File: rtl/lvt_read_select.sv
// rtl/lvt_read_select.sv - live-value table plus per-port bank word selector, 1-cycle latency.
// Optional macro LVT_WRITE_FORWARD_EN forwards same-cycle write data (new-data reads).
module lvt_read_select #(
   parameter int NUM_BANKS = 4,
   parameter int NUM_READ  = 4,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 9,
   parameter int SEL_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input logic             clk,
   input logic             reset,
   lvt_read_select_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [SEL_W-1:0]  lvt_q [DEPTH];
   logic [NUM_READ-1:0] valid_q;
   logic [SEL_W-1:0]  sel_q       [NUM_READ];
   logic [SEL_W-1:0]  sel_d       [NUM_READ];
   logic [DATA_W-1:0] hold_data_q [NUM_READ];
   logic [SEL_W-1:0]  hold_bank_q [NUM_READ];
   logic [DATA_W-1:0] cur_data    [NUM_READ];
   logic [SEL_W-1:0]  cur_bank    [NUM_READ];
`ifdef LVT_WRITE_FORWARD_EN
   logic [NUM_READ-1:0] fwd_q;
   logic [NUM_READ-1:0] fwd_d;
   logic [DATA_W-1:0] fwd_data_q [NUM_READ];
   logic [DATA_W-1:0] fwd_data_d [NUM_READ];
`endif

   // Ascending loop: the highest bank writing an address lands last and wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) lvt_q[i] <= '0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (bus.wr_en[b]) lvt_q[bus.wr_addr[b*ADDR_W +: ADDR_W]] <= SEL_W'(b);
         end
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_READ; p++) begin
         sel_d[p] = sel_q[p];
`ifdef LVT_WRITE_FORWARD_EN
         fwd_d[p]      = 1'b0;
         fwd_data_d[p] = fwd_data_q[p];
`endif
         if (bus.rd_en[p]) begin
            sel_d[p] = lvt_q[bus.rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef LVT_WRITE_FORWARD_EN
            for (int b = 0; b < NUM_BANKS; b++) begin
               if (bus.wr_en[b] &&
                   bus.wr_addr[b*ADDR_W +: ADDR_W] == bus.rd_addr[p*ADDR_W +: ADDR_W]) begin
                  fwd_d[p]      = 1'b1;
                  fwd_data_d[p] = bus.wr_data[b*DATA_W +: DATA_W];
                  sel_d[p]      = SEL_W'(b);
               end
            end
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         for (int p = 0; p < NUM_READ; p++) begin
            sel_q[p]       <= '0;
            hold_data_q[p] <= '0;
            hold_bank_q[p] <= '0;
`ifdef LVT_WRITE_FORWARD_EN
            fwd_data_q[p]  <= '0;
`endif
         end
`ifdef LVT_WRITE_FORWARD_EN
         fwd_q <= '0;
`endif
      end else begin
         valid_q <= bus.rd_en;
         for (int p = 0; p < NUM_READ; p++) begin
            sel_q[p] <= sel_d[p];
            if (valid_q[p]) begin
               hold_data_q[p] <= cur_data[p];
               hold_bank_q[p] <= cur_bank[p];
            end
`ifdef LVT_WRITE_FORWARD_EN
            fwd_data_q[p] <= fwd_data_d[p];
`endif
         end
`ifdef LVT_WRITE_FORWARD_EN
         fwd_q <= fwd_d;
`endif
      end
   end

   // Out-of-range selects (non-power-of-2 bank counts) clamp to the top bank.
   always_comb begin
      bus.rd_data  = '0;
      bus.rd_bank  = '0;
      bus.rd_valid = valid_q;
      for (int p = 0; p < NUM_READ; p++) begin
         cur_bank[p] = (int'(sel_q[p]) >= NUM_BANKS) ? SEL_W'(NUM_BANKS - 1) : sel_q[p];
         cur_data[p] = bus.bank_rd_data[(p*NUM_BANKS + int'(cur_bank[p]))*DATA_W +: DATA_W];
`ifdef LVT_WRITE_FORWARD_EN
         if (fwd_q[p]) cur_data[p] = fwd_data_q[p];
`endif
         bus.rd_data[p*DATA_W +: DATA_W] = valid_q[p] ? cur_data[p] : hold_data_q[p];
         bus.rd_bank[p*SEL_W +: SEL_W]   = valid_q[p] ? cur_bank[p] : hold_bank_q[p];
      end
   end
endmodule

// File: tb/tb_lvt_read_select.sv
// tb/tb_lvt_read_select.sv - directed scoreboard bench for lvt_read_select.
// A small ownership model predicts bank and word; outputs are checked at negedge.
module tb_lvt_read_select;
   localparam int NB = 4;
   localparam int NR = 4;
   localparam int DW = 32;
   localparam int AW = 9;
   localparam int SW = 2;

   typedef struct {
      int          port;
      int          due;
      logic [SW-1:0] bank;
      logic [DW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t sb[$];
   logic [SW-1:0] own [1 << AW];
   logic [DW-1:0] last_data [NR];
   logic [SW-1:0] last_bank [NR];

   lvt_read_select_if #(.NUM_BANKS(NB), .NUM_READ(NR), .DATA_W(DW), .ADDR_W(AW)) bus ();

   lvt_read_select #(.NUM_BANKS(NB), .NUM_READ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [DW-1:0] bw(input int p, input int b, input int c);
      return {4'hA, 4'(p), 4'(b), 4'h5, 16'(c)};
   endfunction

   task automatic clear_model();
      for (int i = 0; i < (1 << AW); i++) own[i] = '0;
      for (int p = 0; p < NR; p++) begin
         last_data[p] = '0;
         last_bank[p] = '0;
      end
      sb.delete();
   endtask

   task automatic wr(input int b, input int addr, input logic [DW-1:0] d);
      bus.wr_en[b] = 1'b1;
      bus.wr_addr[b*AW +: AW] = AW'(addr);
      bus.wr_data[b*DW +: DW] = d;
   endtask

   task automatic rd(input int p, input int addr);
      bus.rd_en[p] = 1'b1;
      bus.rd_addr[p*AW +: AW] = AW'(addr);
   endtask

   task automatic tick();
      exp_t e;
      logic [NR-1:0] mask;
      logic [AW-1:0] a;
      for (int p = 0; p < NR; p++)
         for (int b = 0; b < NB; b++)
            bus.bank_rd_data[(p*NB + b)*DW +: DW] = bw(p, b, cyc);
      @(negedge clk);
      mask = '0;
      foreach (sb[i]) if (sb[i].due == cyc) mask[sb[i].port] = 1'b1;
      check("rd_valid", 128'(bus.rd_valid), 128'(mask));
      while (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         check($sformatf("rd_bank[%0d]", e.port), 128'(bus.rd_bank[e.port*SW +: SW]), 128'(e.bank));
         check($sformatf("rd_data[%0d]", e.port), 128'(bus.rd_data[e.port*DW +: DW]), 128'(e.data));
         last_data[e.port] = e.data;
         last_bank[e.port] = e.bank;
      end
      for (int p = 0; p < NR; p++) begin
         if (!mask[p]) begin
            check($sformatf("hold_data[%0d]", p), 128'(bus.rd_data[p*DW +: DW]), 128'(last_data[p]));
            check($sformatf("hold_bank[%0d]", p), 128'(bus.rd_bank[p*SW +: SW]), 128'(last_bank[p]));
         end
      end
      for (int p = 0; p < NR; p++) begin
         if (bus.rd_en[p]) begin
            a = bus.rd_addr[p*AW +: AW];
            e.port = p;
            e.due  = cyc + 1;
            e.bank = own[a];
            e.data = bw(p, int'(own[a]), cyc + 1);
`ifdef LVT_WRITE_FORWARD_EN
            for (int b = 0; b < NB; b++) begin
               if (bus.wr_en[b] && bus.wr_addr[b*AW +: AW] == a) begin
                  e.bank = SW'(b);
                  e.data = bus.wr_data[b*DW +: DW];
               end
            end
`endif
            sb.push_back(e);
         end
      end
      for (int b = 0; b < NB; b++)
         if (bus.wr_en[b]) own[bus.wr_addr[b*AW +: AW]] = SW'(b);
      @(posedge clk);
      #1;
      cyc++;
      bus.wr_en = '0;
      bus.rd_en = '0;
   endtask

   initial begin
      bus.wr_en = '0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.rd_en = '0;
      bus.rd_addr = '0;
      bus.bank_rd_data = '0;
      clear_model();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_valid", 128'(bus.rd_valid), 128'(0));
      check("reset_data", 128'(bus.rd_data), 128'(0));
      check("reset_bank", 128'(bus.rd_bank), 128'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset ownership: every address belongs to bank 0.
      rd(0, 'h010);
      tick();
      tick();

      // Ownership transfer, then an idle cycle to check hold.
      wr(2, 'h010, 32'h0);
      tick();
      rd(1, 'h010);
      tick();
      tick();
      tick();

      // Same-cycle conflict on the top address.
      wr(1, 'h1FF, 32'h1111_1111);
      wr(3, 'h1FF, 32'h3333_3333);
      tick();
      rd(2, 'h1FF);
      tick();
      tick();

      // Read-during-write on an address still owned by bank 0.
      wr(1, 'h020, 32'hDEAD_BEEF);
      rd(0, 'h020);
      tick();
      rd(0, 'h020);
      tick();
      tick();

      // Parallel ports, back-to-back for 16 cycles.
      for (int b = 0; b < NB; b++) wr(b, 'h040 + b, 32'h0);
      tick();
      for (int k = 0; k < 16; k++) begin
         for (int p = 0; p < NR; p++) rd(p, 'h040 + ((p + k) % NB));
         tick();
      end
      tick();

      // Reset in the same cycle as outstanding reads.
      rd(0, 'h040);
      rd(1, 'h1FF);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("midreset_valid", 128'(bus.rd_valid), 128'(0));
      check("midreset_data", 128'(bus.rd_data), 128'(0));
      clear_model();
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.rd_en = '0;
      cyc++;
      tick();
      rd(0, 'h1FF);
      rd(3, 'h043);
      tick();
      tick();
      tick();
      check("sb_drained", 128'(sb.size()), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lvt_read_select.md
Name: lvt_read_select

Overview:
- Parametrised live-value-table (LVT) plus read-side word selector for the multiported data cache.
- Each of NUM_BANKS write ports owns one replicated bank RAM. The block records which bank last wrote each word address.
- For each of NUM_READ read ports, it selects that port's word from the correct bank. Latency is aligned to the 1-cycle bank RAM read.
- Generalises the fixed 3-to-1 word mux to N banks, M read ports, registered LVT state and conflict resolution.

Parameters:
- NUM_BANKS, 4, number of write ports / replicated banks (2..8).
- NUM_READ, 4, number of read ports.
- DATA_W, 32, word width.
- ADDR_W, 9, word address width; LVT depth = 2^ADDR_W.
- SEL_W, clog2(NUM_BANKS), LVT entry width (derived; minimum 1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- wr_en  in  NUM_BANKS  per-bank write strobe.
- wr_addr  in  NUM_BANKS*ADDR_W  per-bank write address; bank b at slice b.
- wr_data  in  NUM_BANKS*DATA_W  per-bank write data; used only for forwarding.
- rd_en  in  NUM_READ  per-port read request.
- rd_addr  in  NUM_READ*ADDR_W  per-port read address.
- bank_rd_data  in  NUM_READ*NUM_BANKS*DATA_W  bank RAM outputs, 1 cycle after rd_addr; port p, bank b at slice p*NUM_BANKS+b.
- rd_data  out  NUM_READ*DATA_W  selected word per port.
- rd_valid  out  NUM_READ  rd_data valid.
- rd_bank  out  NUM_READ*SEL_W  bank selected for the current rd_data (debug/verification).

Behaviour:
- Reset, asynchronous, active-high. All LVT entries = 0, so bank 0 owns every address. rd_valid = 0, rd_data = 0, rd_bank = 0. Internal pipeline registers are cleared. Reset asserted mid-operation drops any in-flight reads; no rd_valid pulse follows reset release.
- LVT write, at posedge clk:
  - For each b with wr_en[b]=1: LVT[wr_addr[b]] <= b.
  - Several banks writing the same address in one cycle: highest bank index wins.
  - Different addresses update independently in the same cycle.
- Read, cycle N: rd_en[p]=1 with rd_addr[p]. The LVT is read combinationally and registered into sel_q[p]. rd_en is registered into the valid stage.
- Read, cycle N+1:
  - rd_valid[p]=1.
  - rd_bank[p] = sel_q[p].
  - rd_data[p] = bank_rd_data slice (p, sel_q[p]).
  - Output is combinational from the registered select, with no extra register, so total latency is 1 cycle, matching the bank RAM.
- rd_en[p]=0: rd_valid[p]=0 next cycle. rd_data[p] and rd_bank[p] hold their last values.
- Read-during-write, same address, same cycle: the LVT lookup returns the pre-write owner (read-first), consistent with old-data bank RAMs.
- sel_q >= NUM_BANKS, only possible for non-power-of-2 NUM_BANKS: select bank NUM_BANKS-1. Never X.
- Back-to-back reads every cycle are supported on all ports. No stalls, no backpressure.
- Address wrap: addresses are ADDR_W bits with no aliasing beyond depth.

Optional Feature:
- Macro: LVT_WRITE_FORWARD_EN.
- With the macro defined:
  - On a same-cycle read-during-write hit (rd_en[p] && wr_en[b] && rd_addr[p]==wr_addr[b]), the winning write's data (highest b) and index are registered.
  - Next cycle, rd_data[p] = that forwarded wr_data and rd_bank[p] = b, ignoring bank_rd_data.
  - This gives new-data semantics.
- Without the macro: read-first old-data semantics as above, and wr_data is unused.

Test Plan:
- Reset: after release, rd_en[0]=1, addr 0x010; bank_rd_data bank0=0xAAAA0000, bank2=0x22222222 -> next cycle rd_valid[0]=1, rd_bank[0]=0, rd_data[0]=0xAAAA0000.
- Ownership: bank2 writes 0x010; one cycle later, port1 reads 0x010 with bank2 data 0x12345678 -> rd_bank[1]=2, rd_data[1]=0x12345678.
- Conflict: banks 1 and 3 both write 0x1FF in the same cycle; read 0x1FF afterwards -> rd_bank=3.
- Read-during-write: bank1 writes 0x020 (data 0xDEADBEEF) while port0 reads 0x020, prior owner bank0:
  - Without macro -> rd_bank[0]=0, rd_data = bank0 RAM word.
  - With LVT_WRITE_FORWARD_EN -> rd_bank[0]=1, rd_data[0]=0xDEADBEEF.
- Parallel ports: all 4 ports read distinct addresses owned by banks 0..3 every cycle for 16 cycles -> each rd_data matches its owner bank; rd_valid stays high throughout.
- Reset mid-read: assert reset in the same cycle as rd_en=1 -> rd_valid stays 0, and a read of any previously written address returns rd_bank=0.
